rx_instruction: RTL and testbench
=================================

Name: rx_instruction

Overview:
- UART receive front end for the instruction path.
- Deserialises 8N1 bytes from the host on rx and assembles four bytes, least-significant byte first, into a 32-bit instruction word.
- Presents the word to the core over a valid/ready handshake. The core executes it, and the register file is then returned through the transmit path.
- Self-contained: contains its own bit-level receiver, inter-byte timeout and a one-word output holding register.

Parameters:
- CLKS_PER_BIT, 104, clk12 cycles per UART bit (12 MHz / 115200).
- TIMEOUT_CYCLES, 120000, idle cycles after a byte before a partial word is discarded (10 ms).

Ports:
- clk12  input  1  system clock, 12 MHz
- rstn  input  1  reset, synchronous, active-low
- rx  input  1  asynchronous UART line, idle high
- instr  output  32  assembled instruction, byte 0 in [7:0]
- instr_valid  output  1  instr holds an unconsumed word
- instr_ready  input  1  consumer accepts instr this cycle
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full
- timeout  output  1  one-cycle pulse: partial word discarded by inter-byte timeout

Behaviour:
- Reset, on a clk12 edge with rstn=0:
  - instr=0, instr_valid=0, all pulses 0, byte_count=0, timeout counter 0.
  - Both synchroniser flops set to 1; receiver FSM goes to WAIT_IDLE.
- Synchroniser: rx passes through 2 flops; all logic uses the synchronised bit rxs.
- Receiver FSM, states WAIT_IDLE, IDLE, START, DATA, STOP:
  - WAIT_IDLE: go to IDLE once rxs=1. This prevents reset mid-frame from decoding a partial frame.
  - IDLE: on rxs=0, load bit counter with CLKS_PER_BIT/2 and go to START.
  - START: at half-bit, re-sample. If rxs=1, treat as a glitch and return to IDLE. Otherwise go to DATA with bit_idx=0.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after CLKS_PER_BIT.
    - rxs=1: raise internal byte_strobe for 1 cycle, go to IDLE.
    - rxs=0: pulse frame_error, discard the partial word (byte_count=0), go to WAIT_IDLE.
- Assembler:
  - On byte_strobe, write the byte to shift[8*byte_count +: 8] and increment byte_count (2 bits, wraps 3->0).
  - On the 4th byte (byte_count==3), the word is complete.
- Holding register:
  - A complete word loads instr and sets instr_valid if instr_valid==0, or if instr_valid==1 and instr_ready==1 in the same cycle. The latter is a simultaneous consume and refill; valid stays 1 and the new word appears.
  - Otherwise pulse overrun, drop the new word, and leave instr/instr_valid unchanged.
- Handshake:
  - instr_valid clears on an edge where instr_valid=1, instr_ready=1 and no word completes.
  - instr is stable while instr_valid=1.
  - instr_ready while instr_valid=0 is ignored.
- Latency: instr_valid rises 2 clk12 edges after the edge sampling the 4th stop bit (byte_strobe, then load).
- Timeout:
  - The counter clears on every byte_strobe and whenever byte_count==0.
  - It increments while byte_count!=0 and the receiver is IDLE.
  - On reaching TIMEOUT_CYCLES: byte_count=0, pulse timeout, counter clears.
  - A byte completing in the same cycle has priority; there is no timeout that cycle.
- Priority: rstn over everything, then frame_error handling, then byte_strobe, then timeout.
- Reset mid-operation:
  - The pending instr_valid word is lost.
  - Any in-flight frame is ignored until the line returns high.

Test Plan:
- Send bytes 0x93,0x00,0xA0,0x00 with instr_ready=0 -> instr=0x00A00093 and instr_valid=1 exactly 2 edges after the last stop-bit sample; holds until instr_ready=1 for 1 cycle, then instr_valid=0.
- Send two words 0x00A00093 then 0x00108113 with instr_ready tied 0 -> second word produces a 1-cycle overrun pulse; instr stays 0x00A00093.
- Assert instr_ready on the exact cycle the second word completes -> instr_valid stays 1 and instr=0x00108113; no overrun.
- Send 2 bytes, idle TIMEOUT_CYCLES -> timeout pulse, then 0x93,0x00,0xA0,0x00 -> instr=0x00A00093, not corrupted by the stale bytes.
- Byte with stop bit forced 0 after 1 good byte -> frame_error pulse and no valid; after rx returns high, a full word is received correctly. Separately, a 20-cycle low glitch on idle rx -> no byte, no error.
- Assert rstn=0 mid-byte while rx is low, release -> all outputs 0; the remainder of that frame is not decoded; the next clean word is received correctly.

Source files
------------

// File: rtl/rx_instruction.sv
// -----------------------------------------------------------------------------
// rx_instruction
//
// UART receive front end for the instruction path. Deserialises 8N1 bytes
// from the host, assembles four of them (least-significant byte first) into a
// 32-bit instruction word and offers that word to the core over a
// valid/ready handshake through a one-word holding register.
//
// Parameters:
//   CLKS_PER_BIT    clk12 cycles per UART bit (12 MHz / 115200 -> 104)
//   TIMEOUT_CYCLES  idle cycles after a byte before a partial word is dropped
//
// Ports:
//   clk12        in   1   system clock
//   rstn         in   1   synchronous active-low reset
//   rx           in   1   asynchronous UART line, idle high
//   instr        out  32  assembled instruction, byte 0 in [7:0]
//   instr_valid  out  1   instr holds an unconsumed word
//   instr_ready  in   1   consumer accepts instr this cycle
//   frame_error  out  1   one-cycle pulse: stop bit sampled low
//   overrun      out  1   one-cycle pulse: completed word dropped (register full)
//   timeout      out  1   one-cycle pulse: partial word dropped by timeout
// -----------------------------------------------------------------------------
module rx_instruction #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        frame_error,
  output logic        overrun,
  output logic        timeout
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to the idle level.
  // ---------------------------------------------------------------------------
  logic       rx_meta_reg;
  logic       rxs_reg;
  // Counts edges since reset release until the synchroniser holds real line
  // samples. Without it, the reset value 1 in the flops would let WAIT_IDLE
  // exit while the line is still low mid-frame, and the frame tail would be
  // decoded as a new byte.
  logic [1:0] sync_fill_reg;

  always_ff @(posedge clk12) begin
    if (!rstn) begin
      rx_meta_reg   <= 1'b1;
      rxs_reg       <= 1'b1;
      sync_fill_reg <= 2'd0;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
      if (sync_fill_reg != 2'd2) begin
        sync_fill_reg <= sync_fill_reg + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-level receiver FSM
  // ---------------------------------------------------------------------------
  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       data_reg, data_next;
  logic             byte_strobe_reg, byte_strobe_next;
  logic             frame_error_reg, frame_error_next;

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    bit_idx_next     = bit_idx_reg;
    data_next        = data_reg;
    byte_strobe_next = 1'b0;
    frame_error_next = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        if (sync_fill_reg == 2'd2 && rxs_reg) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (!rxs_reg) begin
          bit_cnt_next = HALF_BIT;
          state_next   = START;
        end
      end

      START: begin
        if (bit_cnt_reg == CNT_ONE) begin
          if (rxs_reg) begin
            // Line went back high before mid start bit: a glitch.
            state_next = IDLE;
          end else begin
            bit_idx_next = 3'd0;
            bit_cnt_next = FULL_BIT;
            state_next   = DATA;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - CNT_ONE;
        end
      end

      DATA: begin
        if (bit_cnt_reg == CNT_ONE) begin
          // LSB arrives first, so shift in from the top.
          data_next    = {rxs_reg, data_reg[7:1]};
          bit_cnt_next = FULL_BIT;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - CNT_ONE;
        end
      end

      STOP: begin
        if (bit_cnt_reg == CNT_ONE) begin
          if (rxs_reg) begin
            byte_strobe_next = 1'b1;
            state_next       = IDLE;
          end else begin
            // Bad framing: resynchronise on the next high line level.
            frame_error_next = 1'b1;
            state_next       = WAIT_IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - CNT_ONE;
        end
      end

      default: begin
        state_next = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk12) begin
    if (!rstn) begin
      state_reg       <= WAIT_IDLE;
      bit_cnt_reg     <= '0;
      bit_idx_reg     <= 3'd0;
      data_reg        <= 8'd0;
      byte_strobe_reg <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      data_reg        <= data_next;
      byte_strobe_reg <= byte_strobe_next;
      frame_error_reg <= frame_error_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembler and inter-byte timeout.
  // Priority: frame error, then completed byte, then timeout.
  // ---------------------------------------------------------------------------
  logic [1:0]      byte_count_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_reg;
  logic            word_done_reg;
  logic [31:0]     word_reg;
  logic [7:0]      shift_reg [0:2];

  // Bytes 0..2 are parked here; byte 3 goes straight into the finished word.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shift
      always_ff @(posedge clk12) begin
        if (!rstn) begin
          shift_reg[gi] <= 8'd0;
        end else if (!frame_error_next && byte_strobe_reg &&
                     byte_count_reg == 2'(gi)) begin
          shift_reg[gi] <= data_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk12) begin
    if (!rstn) begin
      byte_count_reg <= 2'd0;
      to_cnt_reg     <= '0;
      timeout_reg    <= 1'b0;
      word_done_reg  <= 1'b0;
      word_reg       <= 32'd0;
    end else begin
      timeout_reg   <= 1'b0;
      word_done_reg <= 1'b0;
      if (frame_error_next) begin
        byte_count_reg <= 2'd0;
        to_cnt_reg     <= '0;
      end else if (byte_strobe_reg) begin
        byte_count_reg <= byte_count_reg + 2'd1;
        to_cnt_reg     <= '0;
        if (byte_count_reg == 2'd3) begin
          word_done_reg <= 1'b1;
          word_reg      <= {data_reg, shift_reg[2], shift_reg[1], shift_reg[0]};
        end
      end else if (byte_count_reg == 2'd0) begin
        to_cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
        // Only time the gap between frames, not a frame in progress.
        if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          byte_count_reg <= 2'd0;
          timeout_reg    <= 1'b1;
          to_cnt_reg     <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One-word holding register with valid/ready handshake.
  // A finished word may replace the held one only when it is consumed on the
  // same edge; otherwise the new word is dropped and overrun pulses.
  // ---------------------------------------------------------------------------
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        overrun_reg;

  always_ff @(posedge clk12) begin
    if (!rstn) begin
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (word_done_reg) begin
        if (!instr_valid_reg || instr_ready) begin
          instr_reg       <= word_reg;
          instr_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (instr_valid_reg && instr_ready) begin
        instr_valid_reg <= 1'b0;
      end
    end
  end

  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rx_instruction.sv
// -----------------------------------------------------------------------------
// tb_rx_instruction
//
// Self-checking bench for rx_instruction. Expected words are pushed to a
// scoreboard queue when the bytes are sent and popped when the holding
// register loads a word. Pulse outputs are counted by a monitor and the
// counts are compared per scenario.
// -----------------------------------------------------------------------------
module tb_rx_instruction;

  localparam int CPB      = 64;
  localparam int HALF     = CPB / 2;
  localparam int TO       = 2000;
  // Edges from the start of byte 0 to the edge loading the word:
  // 3 bytes, then 2 sync + 1 detect edge, half bit, 9 bits, strobe, load.
  localparam int LOAD_OFF = 30 * CPB + 3 + HALF + 9 * CPB + 2;

  localparam logic [31:0] W1 = 32'h00A00093;
  localparam logic [31:0] W2 = 32'h00108113;

  logic        clk12 = 1'b0;
  logic        rstn  = 1'b0;
  logic        rx    = 1'b1;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        frame_error;
  logic        overrun;
  logic        timeout;

  rx_instruction #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk12       (clk12),
    .rstn        (rstn),
    .rx          (rx),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk12 = ~clk12;

  int cyc = 0;
  always @(posedge clk12) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];

  int n_overrun = 0;
  int n_frame   = 0;
  int n_timeout = 0;
  int n_load    = 0;
  int last_load_cyc = 0;

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pinstr = 32'd0;
  logic        p_ov = 1'b0;
  logic        p_fe = 1'b0;
  logic        p_to = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor, sampling on the falling edge. A load happened on the last rising
  // edge if valid is now set and either the register was empty or it was being
  // consumed on that edge.
  always @(negedge clk12) begin
    if (instr_valid && (!pv || pr)) begin
      n_load        <= n_load + 1;
      last_load_cyc <= cyc;
      $display("word 0x%08h loaded at cycle %0d", instr, cyc);
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'(exp_q.size()), 1);
      end else begin
        chk("word", instr, exp_q.pop_front());
      end
    end
    if (instr_valid && pv && !pr) chk("instr_stable", instr, pinstr);
    if (overrun) begin
      n_overrun <= n_overrun + 1;
      chk("overrun_width", 32'(p_ov), 0);
    end
    if (frame_error) begin
      n_frame <= n_frame + 1;
      chk("frame_error_width", 32'(p_fe), 0);
    end
    if (timeout) begin
      n_timeout <= n_timeout + 1;
      chk("timeout_width", 32'(p_to), 0);
    end
    pv     <= instr_valid;
    pr     <= instr_ready;
    pinstr <= instr;
    p_ov   <= overrun;
    p_fe   <= frame_error;
    p_to   <= timeout;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  // Caller must be positioned 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
    end
  endtask

  task automatic ready_at(input int t);
    while (cyc < t) idle(1);
    instr_ready = 1'b1;
    idle(1);
    instr_ready = 1'b0;
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    idle(1);
    instr_ready = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_frame_error"}, 32'(frame_error), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int ov0, fe0, to0, ld0;
    int waited;

    // ---- reset state ----
    idle(5);
    chk_outputs_zero("reset");
    rstn = 1'b1;
    idle(20);

    // ---- basic word, latency, hold, consume ----
    k0 = cyc;
    exp_q.push_back(W1);
    send_word(W1);
    chk("t1_latency", 32'(last_load_cyc), 32'(k0 + LOAD_OFF));
    idle(50);
    chk("t1_valid_held", 32'(instr_valid), 1);
    chk("t1_instr", instr, W1);
    consume();
    chk("t1_valid_cleared", 32'(instr_valid), 0);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);

    // ---- overrun: second word while full ----
    ov0 = n_overrun;
    exp_q.push_back(W1);
    send_word(W1);
    send_word(W2);
    idle(10);
    chk("t2_overrun_count", 32'(n_overrun - ov0), 1);
    chk("t2_instr_kept", instr, W1);
    chk("t2_valid", 32'(instr_valid), 1);

    // ---- simultaneous consume and refill ----
    ov0 = n_overrun;
    k0 = cyc;
    exp_q.push_back(W2);
    fork
      send_word(W2);
      ready_at(k0 + LOAD_OFF - 1);
    join
    idle(10);
    chk("t3_refill_cycle", 32'(last_load_cyc), 32'(k0 + LOAD_OFF));
    chk("t3_valid", 32'(instr_valid), 1);
    chk("t3_instr", instr, W2);
    chk("t3_no_overrun", 32'(n_overrun - ov0), 0);
    consume();
    chk("t3_valid_cleared", 32'(instr_valid), 0);

    // ---- inter-byte timeout ----
    to0 = n_timeout;
    ld0 = n_load;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(TO - 200);
    chk("t4_no_early_timeout", 32'(n_timeout - to0), 0);
    waited = 0;
    while (n_timeout == to0 && waited < 400) begin
      idle(1);
      waited++;
    end
    chk("t4_timeout_count", 32'(n_timeout - to0), 1);
    chk("t4_no_word", 32'(n_load - ld0), 0);
    exp_q.push_back(W1);
    send_word(W1);
    idle(10);
    chk("t4_instr_after_timeout", instr, W1);
    consume();

    // ---- frame error after one good byte ----
    fe0 = n_frame;
    ld0 = n_load;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b0);
    idle(4 * CPB);
    chk("t5_frame_error_count", 32'(n_frame - fe0), 1);
    chk("t5_no_word", 32'(n_load - ld0), 0);
    chk("t5_valid", 32'(instr_valid), 0);
    exp_q.push_back(W2);
    send_word(W2);
    idle(10);
    chk("t5_instr_after_error", instr, W2);
    consume();

    // ---- short low glitch on idle line ----
    fe0 = n_frame;
    ld0 = n_load;
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_no_error", 32'(n_frame - fe0), 0);
    chk("glitch_no_word", 32'(n_load - ld0), 0);
    exp_q.push_back(W1);
    send_word(W1);
    idle(10);
    chk("glitch_instr_after", instr, W1);
    consume();

    // ---- reset mid-byte with a pending word ----
    exp_q.push_back(W2);
    send_word(W2);
    idle(10);
    chk("t6_pending_valid", 32'(instr_valid), 1);
    fe0 = n_frame;
    fork
      send_byte(8'h00, 1'b1);
      begin
        idle(3 * CPB);
        rstn = 1'b0;
        idle(4);
        chk_outputs_zero("t6_in_reset");
        rstn = 1'b1;
        idle(1);
        chk("t6_valid_after_release", 32'(instr_valid), 0);
      end
    join
    ld0 = n_load;
    idle(4 * CPB);
    chk_outputs_zero("t6_after_frame");
    chk("t6_no_word", 32'(n_load - ld0), 0);
    chk("t6_no_frame_error", 32'(n_frame - fe0), 0);
    exp_q.push_back(W1);
    send_word(W1);
    idle(10);
    chk("t6_instr_clean_word", instr, W1);
    consume();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
